mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester (IF) and the data load/store requester (DM) of the single-cycle core.
- Allows one outstanding transaction at a time.
- DM has fixed priority over IF, with a streak limit that guarantees fetch progress.
- Sits between the core's fetch/data paths and the memory. The core stalls its PC update until if_rvalid.

Parameters:
- DATA_STREAK_MAX, 4, max consecutive DM grants while if_req is pending before IF is forced to win; legal range 1..15.
- TIMEOUT_CYCLES, 255, cycles in ISSUE+WAIT before abort; used only with ARB_TIMEOUT_EN; range 1..65535.

Ports:
- SYS_clk  in  1  clock, rising edge.
- SYS_reset  in  1  one clock; reset is asynchronous and active-low (0 = reset).
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  one-cycle pulse: IF request latched.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  32  fetched word.
- dm_req  in  1  data request; held with payload until dm_gnt.
- dm_we  in  1  1 = store, 0 = load.
- dm_len  in  2  01 byte, 10 half, 11 word (00 treated as 11).
- dm_signed  in  1  load sign-extend.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data.
- dm_gnt  out  1  one-cycle pulse: DM request latched.
- dm_rvalid  out  1  one-cycle pulse: load data valid / store done.
- dm_rdata  out  32  load data (0 for stores).
- mem_req  out  1  memory request; held until mem_gnt.
- mem_we  out  1  write enable.
- mem_len  out  2  access length.
- mem_signed  out  1  sign-extend.
- mem_addr  out  32  address.
- mem_wdata  out  32  write data.
- mem_gnt  in  1  memory accepted request this cycle.
- mem_rvalid  in  1  response valid; at least one cycle after mem_gnt; for writes too.
- mem_rdata  in  32  response data.
- busy  out  1  state != IDLE.
- err  out  1  one-cycle abort pulse (timeout only).

Behaviour:
- All outputs are registered.
- Reset values: every output 0; state IDLE; streak counter 0; owner IF.
- States and transitions:
  - IDLE: arbitrate on sampled requests. With no request, stay in IDLE.
  - IDLE → ISSUE at the edge where dm_req or if_req is 1. Latch the winner's payload into mem_* and pulse the winner's gnt in the first ISSUE cycle.
  - ISSUE: mem_req = 1 with stable payload. A cycle with mem_gnt = 1 → WAIT on the next edge, mem_req = 0.
  - WAIT: a cycle with mem_rvalid = 1 → IDLE on the next edge. In that IDLE cycle, the owner's x_rvalid = 1 and x_rdata = mem_rdata.
  - mem_rvalid outside WAIT, and mem_gnt outside ISSUE, are ignored.
- Minimum latency, with zero-wait memory: req sampled at edge 0; gnt + mem_req in cycle 1; mem_gnt in cycle 1; mem_rvalid in cycle 2; x_rvalid in cycle 3. The next grant can be latched at the edge that ends cycle 3.
- A fetch drives mem_we = 0, mem_len = 11, mem_signed = 0, mem_addr = {if_addr[31:2], 2'b00}.
- A DM request passes dm_* through. dm_len 00 maps to 11.
- Arbitration, evaluated at IDLE edges:
  - Only dm_req: DM wins.
  - Only if_req: IF wins.
  - Both: DM wins unless streak == DATA_STREAK_MAX, in which case IF wins.
- Streak counter:
  - +1 (saturating) on a DM grant while if_req = 1.
  - Cleared on any IF grant.
  - Cleared on a DM grant while if_req = 0.
- A requester that keeps req high in the cycle after its gnt is not re-served until the arbiter returns to IDLE. Only one transaction is ever in flight.
- Async reset mid-transaction drops the transaction: mem_req is 0 immediately and no rvalid is issued. A stale mem_rvalid after release is ignored (IDLE).
- err is always 0 unless ARB_TIMEOUT_EN is defined.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined: a 16-bit counter clears at IDLE→ISSUE and increments each ISSUE/WAIT cycle. When it reaches TIMEOUT_CYCLES with no completion, on the next edge:
  - mem_req drops and state returns to IDLE;
  - the owner's x_rvalid pulses with x_rdata = 0;
  - err pulses 1;
  - the streak counter is unchanged.
- Not defined: no counter, err tied 0; the arbiter waits indefinitely.

Test Plan:
- Single fetch, zero-wait memory (mem_gnt immediate, mem_rvalid next cycle, data 0x00000013), if_addr = 0x00000006 → if_gnt cycle 1, mem_addr = 0x00000004, mem_len = 11, if_rvalid = 1 with if_rdata = 0x00000013 in cycle 3.
- if_req and dm_req both held high, DATA_STREAK_MAX = 4 → grant order DM, DM, DM, DM, IF, DM…; never 5 consecutive DM grants.
- DM store sb: dm_addr = 0x100, dm_wdata = 0xAB, mem_gnt delayed 3 cycles → mem_req stays high with stable payload (mem_len = 01, mem_we = 1) for 4 cycles; dm_rvalid = 1 with dm_rdata = 0 the cycle after mem_rvalid.
- Reset asserted (0) while in WAIT, then released; memory returns mem_rvalid one cycle after release → no if_rvalid/dm_rvalid, busy = 0, all outputs 0.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES = 8, mem_gnt never asserted → after 8 ISSUE cycles: mem_req = 0, if_rvalid = 1, if_rdata = 0, err = 1 for one cycle, then IDLE.
- dm_len = 00 load at 0x200, dm_signed = 1 → mem_len = 11, mem_signed = 1, dm_rdata = mem_rdata = 0xFFFF8000.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch (IF) and
// data load/store (DM). One transaction in flight; DM has priority, bounded by a streak
// limit so fetch always makes progress. All outputs are registered.
// Optional macro ARB_TIMEOUT_EN: aborts a transaction stuck in ISSUE/WAIT for
// TIMEOUT_CYCLES cycles, pulsing err and returning zero data to the owner.
module mem_port_arbiter #(
  parameter int unsigned DATA_STREAK_MAX = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [1:0]  dm_len,
  input  logic        dm_signed,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_len,
  output logic        mem_signed,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  localparam logic [3:0] StreakMax = 4'(DATA_STREAK_MAX);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;  // 1 = DM owns the transaction, 0 = IF
  logic [3:0]  streak_q, streak_d;
  logic        if_gnt_q, if_gnt_d, if_rvalid_q, if_rvalid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        dm_gnt_q, dm_gnt_d, dm_rvalid_q, dm_rvalid_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d, mem_signed_q, mem_signed_d;
  logic [1:0]  mem_len_q, mem_len_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic        busy_q, busy_d;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_q, tmo_d;
  logic        err_q, err_d;
`endif

  // Next-state: arbitration in IDLE, handshake tracking in ISSUE/WAIT, optional abort.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    streak_d     = streak_q;
    if_gnt_d     = 1'b0;
    if_rvalid_d  = 1'b0;
    if_rdata_d   = '0;
    dm_gnt_d     = 1'b0;
    dm_rvalid_d  = 1'b0;
    dm_rdata_d   = '0;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_len_d    = mem_len_q;
    mem_signed_d = mem_signed_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
`ifdef ARB_TIMEOUT_EN
    tmo_d        = tmo_q;
    err_d        = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (dm_req || if_req) begin
          state_d   = StIssue;
          mem_req_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          tmo_d     = '0;
`endif
          if (dm_req && (!if_req || streak_q != StreakMax)) begin
            owner_d      = 1'b1;
            dm_gnt_d     = 1'b1;
            mem_we_d     = dm_we;
            mem_len_d    = (dm_len == 2'b00) ? 2'b11 : dm_len;
            mem_signed_d = dm_signed;
            mem_addr_d   = dm_addr;
            mem_wdata_d  = dm_wdata;
            // Streak only counts DM wins that made a waiting fetch wait longer.
            if (if_req) begin
              streak_d = (streak_q == 4'hF) ? streak_q : streak_q + 4'd1;
            end else begin
              streak_d = '0;
            end
          end else begin
            owner_d      = 1'b0;
            if_gnt_d     = 1'b1;
            mem_we_d     = 1'b0;
            mem_len_d    = 2'b11;
            mem_signed_d = 1'b0;
            mem_addr_d   = if_addr & 32'hFFFF_FFFC;
            mem_wdata_d  = '0;
            streak_d     = '0;
          end
        end
      end
      StIssue: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (mem_rvalid) begin
          state_d = StIdle;
          if (owner_q) begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = mem_we_q ? 32'h0 : mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
        end
      end
      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
      end
    endcase

`ifdef ARB_TIMEOUT_EN
    if (state_q != StIdle) begin
      tmo_d = tmo_q + 16'd1;
      // A completion arriving in the last allowed cycle wins over the abort.
      if (tmo_q == TmoLast && !(state_q == StWait && mem_rvalid)) begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
        err_d     = 1'b1;
        if (owner_q) begin
          dm_rvalid_d = 1'b1;
          dm_rdata_d  = '0;
        end else begin
          if_rvalid_d = 1'b1;
          if_rdata_d  = '0;
        end
      end
    end
`endif

    busy_d = (state_d != StIdle);
  end

  // State and registered outputs; reset drops any transaction in flight.
  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      streak_q     <= '0;
      if_gnt_q     <= 1'b0;
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      dm_gnt_q     <= 1'b0;
      dm_rvalid_q  <= 1'b0;
      dm_rdata_q   <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_len_q    <= '0;
      mem_signed_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      tmo_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      streak_q     <= streak_d;
      if_gnt_q     <= if_gnt_d;
      if_rvalid_q  <= if_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      dm_gnt_q     <= dm_gnt_d;
      dm_rvalid_q  <= dm_rvalid_d;
      dm_rdata_q   <= dm_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_len_q    <= mem_len_d;
      mem_signed_q <= mem_signed_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
`ifdef ARB_TIMEOUT_EN
      tmo_q        <= tmo_d;
      err_q        <= err_d;
`endif
    end
  end

  assign if_gnt     = if_gnt_q;
  assign if_rvalid  = if_rvalid_q;
  assign if_rdata   = if_rdata_q;
  assign dm_gnt     = dm_gnt_q;
  assign dm_rvalid  = dm_rvalid_q;
  assign dm_rdata   = dm_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_len    = mem_len_q;
  assign mem_signed = mem_signed_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign err        = err_q;
`else
  // No timeout hardware: constant 0 for every legal TIMEOUT_CYCLES (1..65535).
  assign err        = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases plus randomized request
// traffic against a transaction-level model of the arbitration and memory protocol.
module tb_mem_port_arbiter;

  localparam int unsigned StreakMax = 4;
  localparam int unsigned TmoCycles = 8;

  logic        SYS_clk, SYS_reset;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_signed, dm_gnt, dm_rvalid;
  logic [1:0]  dm_len;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_signed, mem_gnt, mem_rvalid;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, err;

  mem_port_arbiter #(
    .DATA_STREAK_MAX(StreakMax),
    .TIMEOUT_CYCLES (TmoCycles)
  ) dut (
    .SYS_clk   (SYS_clk),
    .SYS_reset (SYS_reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_len    (dm_len),
    .dm_signed (dm_signed),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_len   (mem_len),
    .mem_signed(mem_signed),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .err       (err)
  );

  initial SYS_clk = 1'b0;
  always #5 SYS_clk = ~SYS_clk;

  int total = 0;
  int bad   = 0;

  // Model state: who is waiting, and how many DM wins in a row a waiting fetch has seen.
  bit if_pend, dm_pend;
  int dm_run;
  bit grants[$];  // 1 = DM won, 0 = IF won

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_payload(input logic we, input logic [1:0] len, input logic sg,
                             input logic [31:0] ad, input logic [31:0] wd, input bit is_dm);
    chk("mem_we", 32'(mem_we), 32'(we));
    chk("mem_len", 32'(mem_len), 32'(len));
    chk("mem_signed", 32'(mem_signed), 32'(sg));
    chk("mem_addr", mem_addr, ad);
    if (is_dm) chk("mem_wdata", mem_wdata, wd);
  endtask

  // One complete transaction. Entered and left at #1 after a rising edge with the DUT idle.
  task automatic run_txn(input bit drop, input int gdly, input int rdly,
                         input logic [31:0] rdat);
    bit w_dm;
    logic we, sg;
    logic [1:0] len;
    logic [31:0] ad, wd;
    w_dm = dm_pend && (!if_pend || dm_run < int'(StreakMax));
    if (w_dm) begin
      we = dm_we; len = (dm_len == 2'b00) ? 2'b11 : dm_len; sg = dm_signed;
      ad = dm_addr; wd = dm_wdata;
      dm_run = if_pend ? dm_run + 1 : 0;
    end else begin
      we = 1'b0; len = 2'b11; sg = 1'b0; ad = {if_addr[31:2], 2'b00}; wd = '0;
      dm_run = 0;
    end
    grants.push_back(w_dm);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(posedge SYS_clk); #1;
    chk("if_gnt", 32'(if_gnt), 32'(!w_dm));
    chk("dm_gnt", 32'(dm_gnt), 32'(w_dm));
    chk("mem_req_issue", 32'(mem_req), 32'd1);
    chk("busy_issue", 32'(busy), 32'd1);
    chk_payload(we, len, sg, ad, wd, w_dm);
    if (drop) begin
      if (w_dm) begin dm_pend = 0; dm_req = 1'b0; end
      else begin if_pend = 0; if_req = 1'b0; end
    end
    for (int i = 0; i < gdly; i++) begin
      mem_gnt = 1'b0; mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      @(posedge SYS_clk); #1;
      chk("mem_req_held", 32'(mem_req), 32'd1);
      chk("gnt_once", 32'(if_gnt | dm_gnt), 32'd0);
      chk("no_rvalid_issue", 32'(if_rvalid | dm_rvalid), 32'd0);
      chk_payload(we, len, sg, ad, wd, w_dm);
    end
    mem_gnt = 1'b1; mem_rvalid = 1'($urandom_range(0, 1));
    @(posedge SYS_clk); #1;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk("mem_req_wait", 32'(mem_req), 32'd0);
    chk("busy_wait", 32'(busy), 32'd1);
    for (int i = 0; i < rdly; i++) begin
      mem_gnt = 1'($urandom_range(0, 1));
      @(posedge SYS_clk); #1;
      mem_gnt = 1'b0;
      chk("mem_req_wait2", 32'(mem_req), 32'd0);
      chk("no_rvalid_wait", 32'(if_rvalid | dm_rvalid), 32'd0);
    end
    mem_rvalid = 1'b1; mem_rdata = rdat;
    @(posedge SYS_clk); #1;
    mem_rvalid = 1'b0;
    chk("if_rvalid", 32'(if_rvalid), 32'(!w_dm));
    chk("dm_rvalid", 32'(dm_rvalid), 32'(w_dm));
    if (w_dm) chk("dm_rdata", dm_rdata, we ? 32'h0 : rdat);
    else      chk("if_rdata", if_rdata, rdat);
    chk("busy_done", 32'(busy), 32'd0);
    chk("err_done", 32'(err), 32'd0);
  endtask

  // Randomly raise new requests from idle requesters; always leaves at least one pending.
  task automatic new_reqs();
    if (!if_pend && $urandom_range(0, 1) == 1) begin
      if_pend = 1; if_req = 1'b1; if_addr = $urandom;
    end
    if (!dm_pend && ($urandom_range(0, 1) == 1 || !if_pend)) begin
      dm_pend = 1; dm_req = 1'b1;
      dm_we = 1'($urandom_range(0, 1)); dm_len = 2'($urandom_range(0, 3));
      dm_signed = 1'($urandom_range(0, 1)); dm_addr = $urandom; dm_wdata = $urandom;
    end
  endtask

  initial begin
    bit pat [10];
    pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    SYS_reset = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_len = '0; dm_signed = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    if_pend = 0; dm_pend = 0; dm_run = 0;

    // Reset state
    repeat (2) @(posedge SYS_clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_gnts", 32'(if_gnt | dm_gnt), 32'd0);
    chk("rst_rvalids", 32'(if_rvalid | dm_rvalid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    @(negedge SYS_clk) SYS_reset = 1'b1;
    @(posedge SYS_clk); #1;

    // Single fetch, zero-wait memory, unaligned address
    if_pend = 1; if_req = 1'b1; if_addr = 32'h0000_0006;
    run_txn(1, 0, 0, 32'h0000_0013);

    // Both requesters held high: streak limit forces every fifth grant to IF
    if_pend = 1; if_req = 1'b1; if_addr = 32'h0000_1000;
    dm_pend = 1; dm_req = 1'b1; dm_we = 1'b0; dm_len = 2'b11; dm_signed = 1'b0;
    dm_addr = 32'h0000_0300; dm_wdata = '0;
    grants.delete();
    for (int i = 0; i < 10; i++) run_txn(0, $urandom_range(0, 2), $urandom_range(0, 1), $urandom);
    if_req = 1'b0; dm_req = 1'b0; if_pend = 0; dm_pend = 0;
    for (int i = 0; i < 10; i++) chk($sformatf("order%0d", i), 32'(grants[i]), 32'(pat[i]));

    // Store byte with memory grant delayed 3 cycles
    dm_pend = 1; dm_req = 1'b1; dm_we = 1'b1; dm_len = 2'b01; dm_signed = 1'b0;
    dm_addr = 32'h0000_0100; dm_wdata = 32'h0000_00AB;
    run_txn(1, 3, 0, 32'hDEAD_BEEF);

    // Load with length 00 (word) and sign-extend
    dm_pend = 1; dm_req = 1'b1; dm_we = 1'b0; dm_len = 2'b00; dm_signed = 1'b1;
    dm_addr = 32'h0000_0200; dm_wdata = 32'h1234_5678;
    run_txn(1, 0, 1, 32'hFFFF_8000);

    // Randomized traffic, then drain whatever is still pending
    for (int i = 0; i < 40; i++) begin
      new_reqs();
      run_txn(1, $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
    end
    while (if_pend || dm_pend) run_txn(1, $urandom_range(0, 3), $urandom_range(0, 2), $urandom);

    // Reset while in WAIT, stale mem_rvalid after release
    if_req = 1'b1; if_addr = 32'h0000_0040;
    @(posedge SYS_clk); #1;
    if_req = 1'b0; mem_gnt = 1'b1;
    @(posedge SYS_clk); #1;
    mem_gnt = 1'b0;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 SYS_reset = 1'b0;
    #1;
    chk("async_mem_req", 32'(mem_req), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    dm_run = 0;
    @(negedge SYS_clk) SYS_reset = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(posedge SYS_clk); #1;
    mem_rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("stale_rvalid", 32'(if_rvalid | dm_rvalid), 32'd0);
      chk("stale_busy", 32'(busy), 32'd0);
      chk("stale_mem_req", 32'(mem_req), 32'd0);
      chk("stale_rdata", if_rdata | dm_rdata, 32'h0);
      @(posedge SYS_clk); #1;
    end

`ifdef ARB_TIMEOUT_EN
    // Memory never grants: abort after TmoCycles ISSUE cycles
    if_req = 1'b1; if_addr = 32'h0000_0080; mem_gnt = 1'b0;
    @(posedge SYS_clk); #1;
    if_req = 1'b0;
    chk("tmo_gnt", 32'(if_gnt), 32'd1);
    for (int i = 0; i < int'(TmoCycles); i++) begin
      chk("tmo_mem_req", 32'(mem_req), 32'd1);
      chk("tmo_err_early", 32'(err), 32'd0);
      @(posedge SYS_clk); #1;
    end
    chk("tmo_abort_req", 32'(mem_req), 32'd0);
    chk("tmo_rvalid", 32'(if_rvalid), 32'd1);
    chk("tmo_rdata", if_rdata, 32'h0);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_busy", 32'(busy), 32'd0);
    @(posedge SYS_clk); #1;
    chk("tmo_err_pulse", 32'(err), 32'd0);
    chk("tmo_rvalid_pulse", 32'(if_rvalid), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
